// File: rtl/io64_uart_tx.sv
// io64_uart_tx: captures 16-bit writes to the IO64 output address off the
// write-back RAM bus, queues them in a small FIFO and streams each word out
// as two UART 8N1 frames (low byte first, then high byte).
module io64_uart_tx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] IO_ADDR      = 8'h40
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [7:0]  RAM_ADDR,
  input  logic [15:0] RAM_IN,
  input  logic        RAM_WEN,
  output logic        TX,
  output logic        BUSY,
  output logic        OVERFLOW
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and pointers (one extra MSB distinguishes full from empty)
  logic [15:0]   fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;

  // Transmitter state
  state_t        state_r;
  logic          hi_sel_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic [15:0]   word_r;
  logic [BW-1:0] baud_r;
  logic          tx_r;
  logic          busy_r;
  logic          overflow_r;

  // Combinational control
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          push_req_s;
  logic          push_ok_s;
  logic          pop_s;
  logic          load_word_s;
  logic          baud_tick_s;
  logic          busy_nxt_s;
  logic [15:0]   fifo_rdata_s;

  // FIFO status, push/pop arbitration and next-cycle busy
  always_comb begin
    fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    push_req_s   = RAM_WEN && (RAM_ADDR == IO_ADDR);
    baud_tick_s  = (baud_r == BAUD_LAST);
    // Points where the FSM may fetch a fresh word: idle, or the end of a high-byte stop bit
    load_word_s  = (state_r == IDLE) ||
                   ((state_r == STOP) && baud_tick_s && hi_sel_r);
    pop_s        = load_word_s && !fifo_empty_s;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands
    push_ok_s    = push_req_s && (!fifo_full_s || pop_s);
    // Next state is IDLE only when fetching from an empty FIFO; a same-edge push keeps us busy
    busy_nxt_s   = !(load_word_s && fifo_empty_s && !push_ok_s);
    fifo_rdata_s = fifo_mem_r[rd_ptr_r[AW-1:0]];
  end

  // FIFO data array write port
  always_ff @(posedge CLK) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= RAM_IN;
    end
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (push_req_s && !push_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // UART transmit FSM with baud counter and registered TX/BUSY
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r   <= IDLE;
      hi_sel_r  <= 1'b0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      word_r    <= 16'h0000;
      baud_r    <= {BW{1'b0}};
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;

      // Counter rests at zero while idle so a new frame starts on a clean bit
      if (state_r == IDLE) begin
        baud_r <= {BW{1'b0}};
      end else if (baud_tick_s) begin
        baud_r <= {BW{1'b0}};
      end else begin
        baud_r <= baud_r + BW'(1);
      end

      case (state_r)
        IDLE: begin
          if (pop_s) begin
            word_r   <= fifo_rdata_s;
            shift_r  <= fifo_rdata_s[7:0];
            hi_sel_r <= 1'b0;
            tx_r     <= 1'b0;
            state_r  <= START;
          end else begin
            tx_r <= 1'b1;
          end
        end
        START: begin
          if (baud_tick_s) begin
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
            state_r   <= DATA;
          end
        end
        DATA: begin
          if (baud_tick_s) begin
            if (bit_idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end
        end
        STOP: begin
          if (baud_tick_s) begin
            if (!hi_sel_r) begin
              // Second byte of the same word follows with no gap
              shift_r  <= word_r[15:8];
              hi_sel_r <= 1'b1;
              tx_r     <= 1'b0;
              state_r  <= START;
            end else if (pop_s) begin
              word_r   <= fifo_rdata_s;
              shift_r  <= fifo_rdata_s[7:0];
              hi_sel_r <= 1'b0;
              tx_r     <= 1'b0;
              state_r  <= START;
            end else begin
              tx_r    <= 1'b1;
              state_r <= IDLE;
            end
          end
        end
        default: begin
          tx_r    <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign TX       = tx_r;
  assign BUSY     = busy_r;
  assign OVERFLOW = overflow_r;

endmodule

// File: tb/tb_io64_uart_tx.sv
// tb_io64_uart_tx: directed self-checking bench for io64_uart_tx with
// CLKS_PER_BIT=4 and FIFO_DEPTH=4. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.
module tb_io64_uart_tx;

  logic        CLK;
  logic        RESET_N;
  logic [7:0]  RAM_ADDR;
  logic [15:0] RAM_IN;
  logic        RAM_WEN;
  logic        TX;
  logic        BUSY;
  logic        OVERFLOW;

  int checks;
  int failures;

  io64_uart_tx #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4),
    .IO_ADDR     (8'h40)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .RAM_ADDR(RAM_ADDR),
    .RAM_IN  (RAM_IN),
    .RAM_WEN (RAM_WEN),
    .TX      (TX),
    .BUSY    (BUSY),
    .OVERFLOW(OVERFLOW)
  );

  // 10 ns system clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Expected line level for bit slot 0..19 of a word (two 10-bit 8N1 frames)
  function automatic logic exp_bit(input logic [15:0] w, input int slot);
    if (slot == 0 || slot == 10) return 1'b0;
    else if (slot == 9 || slot == 19) return 1'b1;
    else if (slot < 9) return w[slot - 1];
    else return w[slot - 3];
  endfunction

  task automatic drive(input logic [7:0] a, input logic [15:0] d, input logic en);
    RAM_ADDR = a;
    RAM_IN   = d;
    RAM_WEN  = en;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    drive(8'h00, 16'h0000, 1'b0);
    repeat (3) @(negedge CLK);
    checks++;
    if (TX !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", TX); end
    checks++;
    if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    checks++;
    if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", OVERFLOW); end
    RESET_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (TX !== 1'b1 || BUSY !== 1'b0) begin
      failures++; $display("FAIL post_reset tx=%b busy=%b exp tx=1 busy=0", TX, BUSY);
    end
  endtask

  // Single word 0xA55A: TX falls one cycle after capture, 80 frame cycles, then idle
  task automatic test_single_word();
    logic [15:0] w;
    logic        etx;
    logic        ebusy;
    w = 16'hA55A;
    for (int i = 0; i <= 82; i++) begin
      @(negedge CLK);
      etx   = (i < 2 || i > 81) ? 1'b1 : exp_bit(w, (i - 2) / 4);
      ebusy = (i >= 1 && i <= 81);
      checks++;
      if (TX !== etx) begin failures++; $display("FAIL single_tx i=%0d got=%b exp=%b", i, TX, etx); end
      checks++;
      if (BUSY !== ebusy) begin failures++; $display("FAIL single_busy i=%0d got=%b exp=%b", i, BUSY, ebusy); end
      if (i == 0) drive(8'h40, w, 1'b1);
      else drive(8'h00, 16'h0000, 1'b0);
    end
  endtask

  // Wrong address and disabled writes are ignored
  task automatic test_ignored_writes();
    for (int i = 0; i <= 11; i++) begin
      @(negedge CLK);
      checks++;
      if (TX !== 1'b1) begin failures++; $display("FAIL ignore_tx i=%0d got=%b exp=1", i, TX); end
      checks++;
      if (BUSY !== 1'b0) begin failures++; $display("FAIL ignore_busy i=%0d got=%b exp=0", i, BUSY); end
      if (i == 0) drive(8'h07, 16'h1234, 1'b1);
      else if (i == 1) drive(8'h40, 16'hFFFF, 1'b0);
      else drive(8'h00, 16'h0000, 1'b0);
    end
  endtask

  // Six back-to-back writes: five sent without gaps, sixth dropped, OVERFLOW sticky
  task automatic test_overflow();
    logic [15:0] wexp;
    logic        etx;
    logic        ebusy;
    logic        eovf;
    for (int i = 0; i <= 402; i++) begin
      @(negedge CLK);
      if (i >= 2 && i < 402) begin
        wexp = 16'((i - 2) / 80 + 1);
        etx  = exp_bit(wexp, ((i - 2) % 80) / 4);
      end else begin
        etx = 1'b1;
      end
      ebusy = (i >= 1 && i <= 401);
      eovf  = (i >= 6);
      checks++;
      if (TX !== etx) begin failures++; $display("FAIL ovf_tx i=%0d got=%b exp=%b", i, TX, etx); end
      checks++;
      if (BUSY !== ebusy) begin failures++; $display("FAIL ovf_busy i=%0d got=%b exp=%b", i, BUSY, ebusy); end
      checks++;
      if (OVERFLOW !== eovf) begin failures++; $display("FAIL ovf_flag i=%0d got=%b exp=%b", i, OVERFLOW, eovf); end
      if (i <= 5) drive(8'h40, 16'(i + 1), 1'b1);
      else drive(8'h00, 16'h0000, 1'b0);
    end
  endtask

  // Reset during the high-byte data bits of 0x00FF abandons the frame at once
  task automatic test_reset_mid_frame();
    for (int i = 0; i <= 59; i++) begin
      @(negedge CLK);
      if (i == 0) drive(8'h40, 16'h00FF, 1'b1);
      else drive(8'h00, 16'h0000, 1'b0);
    end
    checks++;
    if (TX !== 1'b0 || BUSY !== 1'b1 || OVERFLOW !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre tx=%b busy=%b ovf=%b exp tx=0 busy=1 ovf=1", TX, BUSY, OVERFLOW);
    end
    RESET_N = 1'b0;
    #1;
    checks++;
    if (TX !== 1'b1) begin failures++; $display("FAIL midreset_tx got=%b exp=1", TX); end
    checks++;
    if (BUSY !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", BUSY); end
    checks++;
    if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL midreset_ovf got=%b exp=0", OVERFLOW); end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      checks++;
      if (TX !== 1'b1 || BUSY !== 1'b0) begin
        failures++; $display("FAIL midreset_after i=%0d tx=%b busy=%b exp tx=1 busy=0", i, TX, BUSY);
      end
    end
  endtask

  // Full FIFO plus write on the same edge as the final stop-bit pop: accepted
  task automatic test_full_pop_push();
    logic [15:0] ws [6];
    logic        etx;
    logic        ebusy;
    ws = '{16'hC301, 16'h5A02, 16'h0F03, 16'hF004, 16'h3C05, 16'h9906};
    for (int i = 0; i <= 482; i++) begin
      @(negedge CLK);
      etx   = (i < 2 || i > 481) ? 1'b1 : exp_bit(ws[(i - 2) / 80], ((i - 2) % 80) / 4);
      ebusy = (i >= 1 && i <= 481);
      checks++;
      if (TX !== etx) begin failures++; $display("FAIL fullpop_tx i=%0d got=%b exp=%b", i, TX, etx); end
      checks++;
      if (BUSY !== ebusy) begin failures++; $display("FAIL fullpop_busy i=%0d got=%b exp=%b", i, BUSY, ebusy); end
      checks++;
      if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL fullpop_ovf i=%0d got=%b exp=0", i, OVERFLOW); end
      if (i <= 4) drive(8'h40, ws[i], 1'b1);
      else if (i == 81) drive(8'h40, ws[5], 1'b1);
      else drive(8'h00, 16'h0000, 1'b0);
    end
  endtask

  // Write 0x8001 on the edge the previous word finishes: exactly one extra idle cycle
  task automatic test_back_to_back();
    logic [15:0] wp;
    logic [15:0] wn;
    logic        etx;
    logic        ebusy;
    wp = 16'h3C3C;
    wn = 16'h8001;
    for (int i = 0; i <= 163; i++) begin
      @(negedge CLK);
      if (i < 2) etx = 1'b1;
      else if (i <= 81) etx = exp_bit(wp, (i - 2) / 4);
      else if (i == 82) etx = 1'b1;
      else if (i <= 162) etx = exp_bit(wn, (i - 83) / 4);
      else etx = 1'b1;
      ebusy = (i >= 1 && i <= 162);
      checks++;
      if (TX !== etx) begin failures++; $display("FAIL b2b_tx i=%0d got=%b exp=%b", i, TX, etx); end
      checks++;
      if (BUSY !== ebusy) begin failures++; $display("FAIL b2b_busy i=%0d got=%b exp=%b", i, BUSY, ebusy); end
      if (i == 0) drive(8'h40, wp, 1'b1);
      else if (i == 81) drive(8'h40, wn, 1'b1);
      else drive(8'h00, 16'h0000, 1'b0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_word();
    test_ignored_writes();
    test_overflow();
    test_reset_mid_frame();
    test_full_pop_push();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
